// File: rtl/uart_pkg.sv
// Shared UART constants, FSM state encodings and the parity helper used by TX and RX.
// Pure declarations: no latency and no backpressure of its own.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  // Parity bit over the low nbits of data; odd mode makes data+parity carry an odd count of ones.
  function automatic logic calc_parity(input logic [8:0] data, input int nbits, input int mode);
    logic x;
    x = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < nbits) x = x ^ data[i];
    end
    return (mode == PARITY_ODD) ? ~x : x;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receiver: 2-flop rxd synchroniser, mid-bit sampling FSM, held output register.
// Result one cycle after the mid-stop sample; held until rx_ready, a frame arriving meanwhile is dropped and flagged.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PARITY_NONE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxd,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
  localparam bit            HAS_PAR   = (PARITY != PARITY_NONE);

  logic                 r_sync1;
  logic                 r_sync2;
  rx_state_t            r_rx_state;
  logic [CW-1:0]        r_rx_cnt;
  logic [IW-1:0]        r_rx_idx;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic                 r_par_err;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_ferr;
  logic                 r_perr;
  logic                 r_ovr;
  logic                 w_rxs;
  logic                 w_done;

  // Preset high so reset never looks like a start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxs  = r_sync2;
  assign w_done = (r_rx_state == RX_STOP) && (r_rx_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_idx   <= '0;
      r_rx_shift <= '0;
      r_par_err  <= 1'b0;
    end else begin
      case (r_rx_state)
        RX_IDLE: begin
          if (!w_rxs) begin
            r_rx_cnt   <= HALF_LAST;
            r_par_err  <= 1'b0;
            r_rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (r_rx_cnt != '0) begin
            r_rx_cnt <= r_rx_cnt - 1'b1;
          end else if (w_rxs) begin
            r_rx_state <= RX_IDLE;
          end else begin
            r_rx_cnt   <= BIT_LAST;
            r_rx_idx   <= '0;
            r_rx_state <= RX_DATA;
          end
        end
        RX_DATA: begin
          if (r_rx_cnt != '0) begin
            r_rx_cnt <= r_rx_cnt - 1'b1;
          end else begin
            r_rx_shift <= {w_rxs, r_rx_shift[DATA_BITS-1:1]};
            r_rx_cnt   <= BIT_LAST;
            if (r_rx_idx == DATA_LAST) r_rx_state <= HAS_PAR ? RX_PARITY : RX_STOP;
            else                       r_rx_idx   <= r_rx_idx + 1'b1;
          end
        end
        RX_PARITY: begin
          if (r_rx_cnt != '0) begin
            r_rx_cnt <= r_rx_cnt - 1'b1;
          end else begin
            r_par_err  <= (w_rxs != calc_parity(9'(r_rx_shift), DATA_BITS, PARITY));
            r_rx_cnt   <= BIT_LAST;
            r_rx_state <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (r_rx_cnt != '0) r_rx_cnt   <= r_rx_cnt - 1'b1;
          else                r_rx_state <= w_rxs ? RX_IDLE : RX_WAIT_HIGH;
        end
        RX_WAIT_HIGH: begin
          if (w_rxs) r_rx_state <= RX_IDLE;
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // A completing frame may overwrite only if the slot is empty or being drained this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_ferr     <= 1'b0;
      r_perr     <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      if (w_done && (!r_rx_valid || rx_ready)) begin
        r_rx_data  <= r_rx_shift;
        r_ferr     <= ~w_rxs;
        r_perr     <= r_par_err;
        r_rx_valid <= 1'b1;
      end else if (w_done) begin
        r_ovr <= 1'b1;
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign rx_data       = r_rx_data;
  assign rx_valid      = r_rx_valid;
  assign rx_frame_err  = r_ferr;
  assign rx_parity_err = r_perr;
  assign rx_overrun    = r_ovr;

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART: inline TX FSM plus uart_rx; TX line goes low the cycle after accept.
// tx_ready stays low for the whole frame, tx_valid meanwhile is ignored; RX holds rx_valid until rx_ready.
module uart_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PARITY_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
  localparam bit            HAS_PAR   = (PARITY != PARITY_NONE);

  tx_state_t            r_tx_state;
  logic [CW-1:0]        r_tx_cnt;
  logic [IW-1:0]        r_tx_idx;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic                 r_tx_par;
  logic                 r_txd;
  logic                 r_tx_ready;

  // Every state dwells CLKS_PER_BIT cycles; STOP repeats that STOP_BITS times via r_tx_idx.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_txd      <= 1'b1;
      r_tx_ready <= 1'b1;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          if (tx_valid && r_tx_ready) begin
            r_tx_shift <= tx_data;
            r_tx_par   <= calc_parity(9'(tx_data), DATA_BITS, PARITY);
            r_txd      <= 1'b0;
            r_tx_ready <= 1'b0;
            r_tx_cnt   <= BIT_LAST;
            r_tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (r_tx_cnt != '0) begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
          end else begin
            r_txd      <= r_tx_shift[0];
            r_tx_shift <= r_tx_shift >> 1;
            r_tx_idx   <= '0;
            r_tx_cnt   <= BIT_LAST;
            r_tx_state <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (r_tx_cnt != '0) begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
          end else begin
            r_tx_cnt <= BIT_LAST;
            if (r_tx_idx != DATA_LAST) begin
              r_txd      <= r_tx_shift[0];
              r_tx_shift <= r_tx_shift >> 1;
              r_tx_idx   <= r_tx_idx + 1'b1;
            end else if (HAS_PAR) begin
              r_txd      <= r_tx_par;
              r_tx_state <= TX_PARITY;
            end else begin
              r_txd      <= 1'b1;
              r_tx_idx   <= '0;
              r_tx_state <= TX_STOP;
            end
          end
        end
        TX_PARITY: begin
          if (r_tx_cnt != '0) begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
          end else begin
            r_txd      <= 1'b1;
            r_tx_idx   <= '0;
            r_tx_cnt   <= BIT_LAST;
            r_tx_state <= TX_STOP;
          end
        end
        TX_STOP: begin
          if (r_tx_cnt != '0) begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
          end else if (r_tx_idx == STOP_LAST) begin
            r_tx_ready <= 1'b1;
            r_tx_state <= TX_IDLE;
          end else begin
            r_tx_idx <= r_tx_idx + 1'b1;
            r_tx_cnt <= BIT_LAST;
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  assign txd      = r_txd;
  assign tx_ready = r_tx_ready;

  uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .DATA_BITS    (DATA_BITS),
    .PARITY       (PARITY)
  ) u_rx (
    .clk           (clk),
    .reset         (reset),
    .rxd           (rxd),
    .rx_ready      (rx_ready),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_frame_err  (rx_frame_err),
    .rx_parity_err (rx_parity_err),
    .rx_overrun    (rx_overrun)
  );

endmodule
